// File: rtl/eth_axis_tx_pkg.sv
// Shared types and constants for the AXI-Stream to eth_rgmii TX buffer loader.
package eth_axis_tx_pkg;

  localparam int unsigned DATA_W        = 64;
  localparam int unsigned KEEP_W        = 8;
  localparam int unsigned LEN_W         = 11;
  localparam int unsigned MIN_FRAME_LEN = 14;
  localparam logic [3:0]  TX_CTRL_ADDR  = 4'h8;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_DROP,
    ST_CMD,
    ST_WAIT_START,
    ST_WAIT_DONE
  } tx_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] be;
  } buf_beat_t;

endpackage

// File: rtl/eth_tkeep_len.sv
// Last-beat tkeep qualifier: LSB-contiguous non-zero check and byte count.
module eth_tkeep_len
  import eth_axis_tx_pkg::*;
(
  input  logic [KEEP_W-1:0] keep,
  output logic              valid_c,
  output logic [3:0]        count_c
);

  logic [KEEP_W-1:0] keep_inc;

  // keep is of the form 0..01..1 exactly when keep & (keep+1) is zero
  always_comb begin
    keep_inc = keep + KEEP_W'(1);
    valid_c  = (keep != '0) && ((keep & keep_inc) == '0);
    count_c  = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      count_c = count_c + 4'(keep[i]);
    end
  end

endmodule

// File: rtl/eth_axis_tx_loader.sv
// Loads one AXI-Stream frame into the eth_rgmii TX buffer, kicks the
// transmitter through the control register and waits for it to finish.
module eth_axis_tx_loader
  import eth_axis_tx_pkg::*;
#(
  parameter int unsigned BUF_AW        = 32,
  parameter logic [31:0] BUF_BASE      = 32'h0000_1000,
  parameter int unsigned MAX_BEATS     = 256,
  parameter logic [31:0] CMD_FLAGS     = 32'h0020_5000,
  parameter int unsigned START_TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [63:0]       s_axis_tdata_i,
  input  logic [7:0]        s_axis_tkeep_i,
  input  logic              s_axis_tlast_i,
  input  logic              s_axis_tvalid_i,
  output logic              s_axis_tready_o,
  output logic              buf_we_o,
  output logic [BUF_AW-1:0] buf_addr_o,
  output logic [63:0]       buf_wdata_o,
  output logic [7:0]        buf_be_o,
  output logic              reg_valid_o,
  output logic [3:0]        reg_addr_o,
  output logic [31:0]       reg_wdata_o,
  input  logic              reg_ready_i,
  input  logic              reg_error_i,
  input  logic              tx_busy_i,
  output logic              frame_done_o,
  output logic              frame_err_o,
  output logic [10:0]       frame_len_o
);

  localparam int unsigned CNT_W   = $clog2(MAX_BEATS + 1);
  localparam int unsigned LFULL_W = CNT_W + 3;
  localparam int unsigned TMR_W   = $clog2(START_TIMEOUT + 1);

  tx_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               tready_q, tready_d;
  logic               buf_we_q, buf_we_d;
  logic [BUF_AW-1:0]  buf_addr_q, buf_addr_d;
  buf_beat_t          beat_q, beat_d;
  logic               reg_valid_q, reg_valid_d;
  logic [3:0]         reg_addr_q, reg_addr_d;
  logic [31:0]        reg_wdata_q, reg_wdata_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               keep_ok;
  logic [3:0]         keep_cnt;
  logic               beat_acc;
  logic               beat_bad;
  logic [LFULL_W-1:0] len_full;
  logic               last_ok;

  eth_tkeep_len u_tkeep_len (
    .keep    (s_axis_tkeep_i),
    .valid_c (keep_ok),
    .count_c (keep_cnt)
  );

  assign beat_acc = s_axis_tvalid_i && tready_q;
  assign beat_bad = (cnt_q >= CNT_W'(MAX_BEATS)) ||
                    (!s_axis_tlast_i && (s_axis_tkeep_i != 8'hFF));
  assign len_full = {cnt_q, 3'b000} + LFULL_W'(keep_cnt);
  // a length that does not fit the length field is treated like a bad frame
  assign last_ok  = keep_ok && (len_full >= LFULL_W'(MIN_FRAME_LEN)) &&
                    ((len_full >> LEN_W) == '0);

  // next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    len_d      = len_q;
    buf_we_d   = 1'b0;
    buf_addr_d = buf_addr_q;
    beat_d     = beat_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (beat_acc) begin
          if (beat_bad) begin
            if (s_axis_tlast_i) begin
              err_d = 1'b1;
              cnt_d = '0;
            end else begin
              state_d = ST_DROP;
            end
          end else begin
            buf_we_d   = 1'b1;
            buf_addr_d = BUF_AW'(BUF_BASE) + BUF_AW'({cnt_q, 3'b000});
            beat_d     = '{data: s_axis_tdata_i, be: s_axis_tkeep_i};
            cnt_d      = cnt_q + CNT_W'(1);
            if (s_axis_tlast_i) begin
              if (last_ok) begin
                len_d   = LEN_W'(len_full);
                state_d = ST_CMD;
              end else begin
                err_d = 1'b1;
                cnt_d = '0;
              end
            end
          end
        end
      end
      ST_DROP: begin
        if (beat_acc && s_axis_tlast_i) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_CMD: begin
        if (reg_valid_q && reg_ready_i) begin
          if (reg_error_i) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_LOAD;
          end else begin
            tmr_d   = '0;
            state_d = ST_WAIT_START;
          end
        end
      end
      ST_WAIT_START: begin
        if (tx_busy_i) begin
          state_d = ST_WAIT_DONE;
        end else if (tmr_q == TMR_W'(START_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy_i) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase

    tready_d = (state_d == ST_LOAD) || (state_d == ST_DROP);
    // first CMD cycle stays idle so the last buffer write lands before the kick
    reg_valid_d = (state_q == ST_CMD) && (state_d == ST_CMD);
    reg_addr_d  = reg_valid_d ? TX_CTRL_ADDR : 4'h0;
    reg_wdata_d = reg_valid_d ? (CMD_FLAGS | 32'(len_q)) : 32'h0;
  end

  // state and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      tmr_q       <= '0;
      len_q       <= '0;
      tready_q    <= 1'b0;
      buf_we_q    <= 1'b0;
      buf_addr_q  <= '0;
      beat_q      <= '0;
      reg_valid_q <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      len_q       <= len_d;
      tready_q    <= tready_d;
      buf_we_q    <= buf_we_d;
      buf_addr_q  <= buf_addr_d;
      beat_q      <= beat_d;
      reg_valid_q <= reg_valid_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign s_axis_tready_o = tready_q;
  assign buf_we_o        = buf_we_q;
  assign buf_addr_o      = buf_addr_q;
  assign buf_wdata_o     = beat_q.data;
  assign buf_be_o        = beat_q.be;
  assign reg_valid_o     = reg_valid_q;
  assign reg_addr_o      = reg_addr_q;
  assign reg_wdata_o     = reg_wdata_q;
  assign frame_done_o    = done_q;
  assign frame_err_o     = err_q;
  assign frame_len_o     = len_q;

endmodule

// File: tb/tb_eth_axis_tx_loader.sv
// Directed self-checking bench for eth_axis_tx_loader.
module tb_eth_axis_tx_loader;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [63:0] s_axis_tdata_i = '0;
  logic [7:0]  s_axis_tkeep_i = '0;
  logic        s_axis_tlast_i = 1'b0;
  logic        s_axis_tvalid_i = 1'b0;
  logic        s_axis_tready_o;
  logic        buf_we_o;
  logic [31:0] buf_addr_o;
  logic [63:0] buf_wdata_o;
  logic [7:0]  buf_be_o;
  logic        reg_valid_o;
  logic [3:0]  reg_addr_o;
  logic [31:0] reg_wdata_o;
  logic        reg_ready_i = 1'b0;
  logic        reg_error_i = 1'b0;
  logic        tx_busy_i = 1'b0;
  logic        frame_done_o;
  logic        frame_err_o;
  logic [10:0] frame_len_o;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  logic [31:0] wr_addr_q[$];
  logic [63:0] wr_data_q[$];
  logic [7:0]  wr_be_q[$];
  int done_n = 0;
  int err_n = 0;
  int err_cyc = 0;
  int rv_rise_n = 0;
  int rv_rise_cyc = 0;
  int last_we_cyc = 0;
  int last_acc_cyc = 0;
  logic rv_prev = 1'b0;

  eth_axis_tx_loader dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .s_axis_tdata_i  (s_axis_tdata_i),
    .s_axis_tkeep_i  (s_axis_tkeep_i),
    .s_axis_tlast_i  (s_axis_tlast_i),
    .s_axis_tvalid_i (s_axis_tvalid_i),
    .s_axis_tready_o (s_axis_tready_o),
    .buf_we_o        (buf_we_o),
    .buf_addr_o      (buf_addr_o),
    .buf_wdata_o     (buf_wdata_o),
    .buf_be_o        (buf_be_o),
    .reg_valid_o     (reg_valid_o),
    .reg_addr_o      (reg_addr_o),
    .reg_wdata_o     (reg_wdata_o),
    .reg_ready_i     (reg_ready_i),
    .reg_error_i     (reg_error_i),
    .tx_busy_i       (tx_busy_i),
    .frame_done_o    (frame_done_o),
    .frame_err_o     (frame_err_o),
    .frame_len_o     (frame_len_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // observer: records buffer writes, pulses and handshake timing
  always @(negedge clk_i) begin
    if (buf_we_o) begin
      wr_addr_q.push_back(buf_addr_o);
      wr_data_q.push_back(buf_wdata_o);
      wr_be_q.push_back(buf_be_o);
      last_we_cyc <= cyc;
    end
    if (reg_valid_o && !rv_prev) begin
      rv_rise_n   <= rv_rise_n + 1;
      rv_rise_cyc <= cyc;
    end
    rv_prev <= reg_valid_o;
    if (frame_done_o) done_n <= done_n + 1;
    if (frame_err_o) begin
      err_n   <= err_n + 1;
      err_cyc <= cyc;
    end
    if (s_axis_tvalid_i && s_axis_tready_o && s_axis_tlast_i) last_acc_cyc <= cyc;
  end

  function automatic logic [63:0] beat_data(input int k);
    return {16'hDA7A, 16'(k), 16'h5A5A, 16'(k)};
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           output logic ok);
    int t;
    t = 0;
    ok = 1'b0;
    s_axis_tdata_i  = d;
    s_axis_tkeep_i  = k;
    s_axis_tlast_i  = l;
    s_axis_tvalid_i = 1'b1;
    while (!ok && t < 100) begin
      @(negedge clk_i);
      ok = s_axis_tready_o;
      @(posedge clk_i); #1;
      t++;
    end
    s_axis_tvalid_i = 1'b0;
    s_axis_tlast_i  = 1'b0;
  endtask

  task automatic send_frame(input int nbeats, input logic [7:0] last_keep,
                            input int bad_idx, input logic [7:0] bad_keep, input string nm);
    logic ok, all_ok;
    logic [7:0] k;
    all_ok = 1'b1;
    for (int i = 0; i < nbeats; i++) begin
      k = (i == nbeats - 1) ? last_keep : ((i == bad_idx) ? bad_keep : 8'hFF);
      send_beat(beat_data(i), k, i == nbeats - 1, ok);
      if (!ok) all_ok = 1'b0;
    end
    n_checks++;
    if (!all_ok) begin
      n_fail++;
      $display("FAIL %s_accept: tready timeout got 0 want 1", nm);
    end
  endtask

  task automatic do_cmd(input int delay, input logic err, input logic [31:0] exp_wdata,
                        input string nm, output int hs_cyc);
    int hi, t;
    logic stable;
    hs_cyc = 0;
    hi = 0;
    t = 0;
    stable = 1'b1;
    @(negedge clk_i);
    while (!reg_valid_o && t < 50) begin
      @(negedge clk_i);
      t++;
    end
    n_checks++;
    if (!reg_valid_o) begin
      n_fail++;
      $display("FAIL %s_reg_valid: got 0 want 1 within 50 cycles", nm);
      return;
    end
    n_checks++;
    if (reg_addr_o !== 4'h8) begin
      n_fail++;
      $display("FAIL %s_reg_addr: got %h want 8", nm, reg_addr_o);
    end
    n_checks++;
    if (reg_wdata_o !== exp_wdata) begin
      n_fail++;
      $display("FAIL %s_reg_wdata: got %h want %h", nm, reg_wdata_o, exp_wdata);
    end
    n_checks++;
    if (s_axis_tready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_tready_cmd: got %b want 0", nm, s_axis_tready_o);
    end
    hi = 1;
    forever begin
      if (hi == delay + 1) begin
        reg_ready_i = 1'b1;
        reg_error_i = err;
      end
      @(posedge clk_i); #1;
      if (reg_ready_i) begin
        reg_ready_i = 1'b0;
        reg_error_i = 1'b0;
        hs_cyc = cyc;
        break;
      end
      @(negedge clk_i);
      if (!reg_valid_o) break;
      hi++;
      if (reg_addr_o !== 4'h8 || reg_wdata_o !== exp_wdata) stable = 1'b0;
    end
    n_checks++;
    if (hi != delay + 1) begin
      n_fail++;
      $display("FAIL %s_reg_hold: got %0d cycles want %0d", nm, hi, delay + 1);
    end
    n_checks++;
    if (!stable) begin
      n_fail++;
      $display("FAIL %s_reg_stable: got unstable addr/data want stable", nm);
    end
    @(negedge clk_i);
    n_checks++;
    if (reg_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_reg_drop: got %b want 0", nm, reg_valid_o);
    end
  endtask

  task automatic run_tx(input int busy_cycles, input string nm);
    repeat (3) @(posedge clk_i);
    #1 tx_busy_i = 1'b1;
    repeat (busy_cycles) @(posedge clk_i);
    #1;
    n_checks++;
    if (s_axis_tready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_tready_busy: got %b want 0", nm, s_axis_tready_o);
    end
    tx_busy_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++;
    if ({s_axis_tready_o, buf_we_o, reg_valid_o, frame_done_o, frame_err_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {s_axis_tready_o, buf_we_o, reg_valid_o, frame_done_o, frame_err_o});
    end
    n_checks++;
    if (frame_len_o !== 11'd0 || buf_addr_o !== 32'h0 || reg_wdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got len=%0d addr=%h wdata=%h want 0", frame_len_o, buf_addr_o,
               reg_wdata_o);
    end
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;
    n_checks++;
    if (s_axis_tready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tready_idle: got %b want 1", s_axis_tready_o);
    end
  endtask

  task automatic test_full_frame();
    int base, d0, hs;
    logic addr_ok, data_ok;
    base = wr_addr_q.size();
    d0 = done_n;
    send_frame(8, 8'hFF, -1, 8'h00, "full");
    do_cmd(0, 1'b0, 32'h0020_5040, "full", hs);
    n_checks++;
    if (last_we_cyc != last_acc_cyc + 1 || rv_rise_cyc != last_acc_cyc + 2) begin
      n_fail++;
      $display("FAIL full_order: got we=+%0d rv=+%0d want we=+1 rv=+2",
               last_we_cyc - last_acc_cyc, rv_rise_cyc - last_acc_cyc);
    end
    run_tx(20, "full");
    n_checks++;
    if (wr_addr_q.size() - base != 8) begin
      n_fail++;
      $display("FAIL full_wr_count: got %0d want 8", wr_addr_q.size() - base);
    end else begin
      addr_ok = 1'b1;
      data_ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (wr_addr_q[base + i] !== 32'h1000 + 32'(8 * i)) addr_ok = 1'b0;
        if (wr_data_q[base + i] !== beat_data(i) || wr_be_q[base + i] !== 8'hFF) data_ok = 1'b0;
      end
      n_checks++;
      if (!addr_ok) begin
        n_fail++;
        $display("FAIL full_wr_addr: got first=%h last=%h want 1000..1038", wr_addr_q[base],
                 wr_addr_q[base + 7]);
      end
      n_checks++;
      if (!data_ok) begin
        n_fail++;
        $display("FAIL full_wr_data: got beat0=%h want %h", wr_data_q[base], beat_data(0));
      end
    end
    n_checks++;
    if (done_n - d0 != 1 || frame_len_o !== 11'd64) begin
      n_fail++;
      $display("FAIL full_done: got done=%0d len=%0d want done=1 len=64", done_n - d0,
               frame_len_o);
    end
  endtask

  task automatic test_min_len();
    int base, d0, e0, r0, hs;
    base = wr_addr_q.size();
    d0 = done_n;
    send_frame(2, 8'h3F, -1, 8'h00, "min14");
    do_cmd(0, 1'b0, 32'h0020_500E, "min14", hs);
    run_tx(5, "min14");
    n_checks++;
    if (done_n - d0 != 1 || frame_len_o !== 11'd14 || wr_be_q[base + 1] !== 8'h3F) begin
      n_fail++;
      $display("FAIL min14_done: got done=%0d len=%0d be=%h want 1 14 3f", done_n - d0,
               frame_len_o, wr_be_q[base + 1]);
    end
    e0 = err_n;
    r0 = rv_rise_n;
    send_frame(2, 8'h1F, -1, 8'h00, "runt13");
    repeat (6) @(posedge clk_i);
    #1;
    n_checks++;
    if (err_n - e0 != 1 || rv_rise_n != r0 || frame_len_o !== 11'd14) begin
      n_fail++;
      $display("FAIL runt13: got err=%0d regreq=%0d len=%0d want 1 0 14", err_n - e0,
               rv_rise_n - r0, frame_len_o);
    end
    e0 = err_n;
    send_frame(3, 8'h0B, -1, 8'h00, "noncontig");
    send_frame(3, 8'h00, -1, 8'h00, "zerokeep");
    repeat (6) @(posedge clk_i);
    #1;
    n_checks++;
    if (err_n - e0 != 2 || rv_rise_n != r0) begin
      n_fail++;
      $display("FAIL bad_last_keep: got err=%0d regreq=%0d want 2 0", err_n - e0, rv_rise_n - r0);
    end
  endtask

  task automatic test_bad_keep_mid();
    int base, e0, r0, d0, hs;
    base = wr_addr_q.size();
    e0 = err_n;
    r0 = rv_rise_n;
    send_frame(4, 8'hFF, 1, 8'h0F, "midkeep");
    repeat (6) @(posedge clk_i);
    #1;
    n_checks++;
    if (wr_addr_q.size() - base != 1 || err_n - e0 != 1 || rv_rise_n != r0) begin
      n_fail++;
      $display("FAIL midkeep_drop: got wr=%0d err=%0d regreq=%0d want 1 1 0",
               wr_addr_q.size() - base, err_n - e0, rv_rise_n - r0);
    end
    base = wr_addr_q.size();
    d0 = done_n;
    send_frame(3, 8'hFF, -1, 8'h00, "after_drop");
    do_cmd(0, 1'b0, 32'h0020_5018, "after_drop", hs);
    run_tx(4, "after_drop");
    n_checks++;
    if (wr_addr_q[base] !== 32'h1000 || done_n - d0 != 1 || frame_len_o !== 11'd24) begin
      n_fail++;
      $display("FAIL after_drop: got addr=%h done=%0d len=%0d want 1000 1 24", wr_addr_q[base],
               done_n - d0, frame_len_o);
    end
  endtask

  task automatic test_oversize();
    int base, e0, r0;
    base = wr_addr_q.size();
    e0 = err_n;
    r0 = rv_rise_n;
    send_frame(257, 8'hFF, -1, 8'h00, "oversize");
    repeat (6) @(posedge clk_i);
    #1;
    n_checks++;
    if (wr_addr_q.size() - base != 256) begin
      n_fail++;
      $display("FAIL oversize_wr_count: got %0d want 256", wr_addr_q.size() - base);
    end else begin
      n_checks++;
      if (wr_addr_q[base + 255] !== 32'h17F8) begin
        n_fail++;
        $display("FAIL oversize_last_addr: got %h want 17f8", wr_addr_q[base + 255]);
      end
    end
    n_checks++;
    if (err_n - e0 != 1 || rv_rise_n != r0) begin
      n_fail++;
      $display("FAIL oversize_err: got err=%0d regreq=%0d want 1 0", err_n - e0, rv_rise_n - r0);
    end
  endtask

  task automatic test_reg_error_and_timeout();
    int e0, d0, hs, t;
    e0 = err_n;
    d0 = done_n;
    send_frame(2, 8'hFF, -1, 8'h00, "regerr");
    do_cmd(5, 1'b1, 32'h0020_5010, "regerr", hs);
    @(posedge clk_i); #1;
    n_checks++;
    if (err_n - e0 != 1 || done_n != d0 || s_axis_tready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL regerr_exit: got err=%0d done=%0d tready=%b want 1 0 1", err_n - e0,
               done_n - d0, s_axis_tready_o);
    end
    e0 = err_n;
    send_frame(2, 8'hFF, -1, 8'h00, "timeout");
    do_cmd(0, 1'b0, 32'h0020_5010, "timeout", hs);
    t = 0;
    while (err_n == e0 && t < 1200) begin
      @(negedge clk_i);
      t++;
    end
    @(posedge clk_i); #1;
    n_checks++;
    if (err_n - e0 != 1) begin
      n_fail++;
      $display("FAIL timeout_err: got %0d pulses want 1 within 1200 cycles", err_n - e0);
    end else begin
      n_checks++;
      if (err_cyc - hs < 1020 || err_cyc - hs > 1030) begin
        n_fail++;
        $display("FAIL timeout_cycles: got %0d want about 1024", err_cyc - hs);
      end
    end
    n_checks++;
    if (done_n != d0 || s_axis_tready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_exit: got done=%0d tready=%b want 0 1", done_n - d0,
               s_axis_tready_o);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic ok;
    int base, e0, d0, hs;
    e0 = err_n;
    for (int i = 0; i < 3; i++) send_beat(beat_data(i), 8'hFF, 1'b0, ok);
    s_axis_tdata_i  = beat_data(3);
    s_axis_tkeep_i  = 8'hFF;
    s_axis_tvalid_i = 1'b1;
    #3 rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({buf_we_o, s_axis_tready_o, reg_valid_o} !== 3'b000 || buf_addr_o !== 32'h0 ||
        frame_len_o !== 11'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got we/rdy/rv=%b addr=%h len=%0d want 0",
               {buf_we_o, s_axis_tready_o, reg_valid_o}, buf_addr_o, frame_len_o);
    end
    repeat (2) @(posedge clk_i);
    s_axis_tvalid_i = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;
    base = wr_addr_q.size();
    d0 = done_n;
    send_frame(2, 8'hFF, -1, 8'h00, "postrst");
    do_cmd(0, 1'b0, 32'h0020_5010, "postrst", hs);
    run_tx(3, "postrst");
    n_checks++;
    if (wr_addr_q[base] !== 32'h1000 || done_n - d0 != 1 || err_n != e0 ||
        frame_len_o !== 11'd16) begin
      n_fail++;
      $display("FAIL postrst: got addr=%h done=%0d err=%0d len=%0d want 1000 1 0 16",
               wr_addr_q[base], done_n - d0, err_n - e0, frame_len_o);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_min_len();
    test_bad_keep_mid();
    test_oversize();
    test_reg_error_and_timeout();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
